// File: rtl/multi_digit_counter_display.sv
// Up/down multi-digit counter (decimal or hex digits) with auto-repeat on held switches
// and registered active-low seven-segment outputs, one 7-bit field per digit.
module multi_digit_counter_display #(
  parameter int NUM_DIGITS   = 2,
  parameter int RADIX        = 16,
  parameter int AUTO_REPEAT  = 1,
  parameter int REPEAT_DELAY = 12_500_000,
  parameter int REPEAT_RATE  = 2_500_000
) (
  input  logic                    i_Clk,
  input  logic                    i_Reset,
  input  logic                    i_Inc,
  input  logic                    i_Dec,
  input  logic                    i_Clear,
  output logic [4*NUM_DIGITS-1:0] o_Count,
  output logic [7*NUM_DIGITS-1:0] o_Segments,
  output logic                    o_Wrap
);

  localparam int MAX_PERIOD = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW = $clog2(MAX_PERIOD + 1);
  localparam logic [TW-1:0] DELAY_LOAD = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RATE_LOAD  = TW'(REPEAT_RATE - 1);
  localparam logic [3:0]    DIGIT_MAX  = 4'(RADIX - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic                    dir_up_q, dir_up_d;
  logic                    inc_prev_q, dec_prev_q;
  logic [4*NUM_DIGITS-1:0] count_q, count_d;
  logic [7*NUM_DIGITS-1:0] seg_q, seg_d;
  logic                    wrap_q, wrap_d;
  logic                    step_s, step_up_s, ripple_s, held_s;
  logic                    inc_rise_s, dec_rise_s;

  function automatic logic [6:0] seg7_encode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  assign inc_rise_s = i_Inc & ~inc_prev_q;
  assign dec_rise_s = i_Dec & ~dec_prev_q;

  // Step arbitration and auto-repeat sequencing
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    dir_up_d  = dir_up_q;
    step_s    = 1'b0;
    step_up_s = 1'b0;
    held_s    = 1'b0;
    if (i_Clear) begin
      state_d = ST_IDLE;
      timer_d = '0;
    end else if (i_Inc && i_Dec) begin
      state_d = ST_IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (inc_rise_s || dec_rise_s) begin
            step_s    = 1'b1;
            step_up_s = inc_rise_s;
            if (AUTO_REPEAT != 0) begin
              state_d  = ST_DELAY;
              dir_up_d = inc_rise_s;
              timer_d  = DELAY_LOAD;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DELAY, ST_REPEAT: begin
          held_s = dir_up_q ? i_Inc : i_Dec;
          if (!held_s) begin
            state_d = ST_IDLE;
            timer_d = '0;
          end else if (timer_q == '0) begin
            step_s    = 1'b1;
            step_up_s = dir_up_q;
            state_d   = ST_REPEAT;
            timer_d   = RATE_LOAD;
          end else begin
            timer_d = timer_q - {{(TW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_d = ST_IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  // Carry/borrow ripple across all digits; the final ripple out is the wrap
  always_comb begin
    count_d  = count_q;
    wrap_d   = 1'b0;
    ripple_s = 1'b0;
    if (i_Clear) begin
      count_d = '0;
    end else if (step_s) begin
      ripple_s = 1'b1;
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if (!ripple_s) begin
          count_d[4*d +: 4] = count_q[4*d +: 4];
        end else if (step_up_s) begin
          if (count_q[4*d +: 4] == DIGIT_MAX) begin
            count_d[4*d +: 4] = 4'd0;
          end else begin
            count_d[4*d +: 4] = count_q[4*d +: 4] + 4'd1;
            ripple_s = 1'b0;
          end
        end else begin
          if (count_q[4*d +: 4] == 4'd0) begin
            count_d[4*d +: 4] = DIGIT_MAX;
          end else begin
            count_d[4*d +: 4] = count_q[4*d +: 4] - 4'd1;
            ripple_s = 1'b0;
          end
        end
      end
      wrap_d = ripple_s;
    end else begin
      count_d = count_q;
    end
  end

  // Segment encode of the registered count
  always_comb begin
    seg_d = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      seg_d[7*d +: 7] = seg7_encode(count_q[4*d +: 4]);
    end
  end

  // State, count and output registers; reset samples the switches so a held one cannot step
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      dir_up_q   <= 1'b0;
      inc_prev_q <= i_Inc;
      dec_prev_q <= i_Dec;
      count_q    <= '0;
      seg_q      <= {NUM_DIGITS{7'h40}};
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      dir_up_q   <= dir_up_d;
      inc_prev_q <= i_Inc;
      dec_prev_q <= i_Dec;
      count_q    <= count_d;
      seg_q      <= seg_d;
      wrap_q     <= wrap_d;
    end
  end

  assign o_Count    = count_q;
  assign o_Segments = seg_q;
  assign o_Wrap     = wrap_q;

endmodule

// File: tb/tb_multi_digit_counter_display.sv
// Directed bench: a decimal auto-repeat instance and a hex edge-only instance,
// checked with immediate assertions against hand-computed values.
module tb_multi_digit_counter_display;

  logic        clk;
  logic        rst;
  logic        d_inc, d_dec, d_clr;
  logic        h_inc, h_dec, h_clr;
  logic [7:0]  d_count, h_count;
  logic [13:0] d_seg, h_seg;
  logic        d_wrap, h_wrap;

  int checks;
  int failures;

  logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int rep_exp [10] = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 4};

  multi_digit_counter_display #(
    .NUM_DIGITS(2), .RADIX(10), .AUTO_REPEAT(1), .REPEAT_DELAY(4), .REPEAT_RATE(2)
  ) u_dec (
    .i_Clk(clk), .i_Reset(rst), .i_Inc(d_inc), .i_Dec(d_dec), .i_Clear(d_clr),
    .o_Count(d_count), .o_Segments(d_seg), .o_Wrap(d_wrap)
  );

  multi_digit_counter_display #(
    .NUM_DIGITS(2), .RADIX(16), .AUTO_REPEAT(0), .REPEAT_DELAY(4), .REPEAT_RATE(2)
  ) u_hex (
    .i_Clk(clk), .i_Reset(rst), .i_Inc(h_inc), .i_Dec(h_dec), .i_Clear(h_clr),
    .o_Count(h_count), .o_Segments(h_seg), .o_Wrap(h_wrap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // which: 0 dec-inst inc, 1 dec-inst dec, 2 hex-inst inc, 3 hex-inst dec
  task automatic pulse(input int which);
    case (which)
      0: d_inc = 1'b1;
      1: d_dec = 1'b1;
      2: h_inc = 1'b1;
      default: h_dec = 1'b1;
    endcase
    tick(1);
    d_inc = 1'b0; d_dec = 1'b0; h_inc = 1'b0; h_dec = 1'b0;
    tick(1);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1;
    d_inc = 1'b1; d_dec = 1'b0; d_clr = 1'b0;
    h_inc = 1'b0; h_dec = 1'b0; h_clr = 1'b0;
    tick(2);
    check("rst_count", 32'(d_count), 32'h00);
    check("rst_seg", 32'(d_seg), 32'h2040);
    check("rst_wrap", 32'(d_wrap), 32'h0);
    check("rst_hex_seg", 32'(h_seg), 32'h2040);

    rst = 1'b0;
    tick(10);
    check("held_thru_rst_count", 32'(d_count), 32'h00);
    check("held_thru_rst_seg", 32'(d_seg), 32'h2040);
    d_inc = 1'b0;
    tick(1);

    for (int i = 0; i < 9; i++) pulse(0);
    check("bcd_9_count", 32'(d_count), 32'h09);
    check("bcd_9_seg", 32'(d_seg), 32'h2010);
    pulse(0);
    check("bcd_carry_count", 32'(d_count), 32'h10);
    check("bcd_carry_seg", 32'(d_seg), 32'h3CC0);
    pulse(1);
    check("bcd_borrow_count", 32'(d_count), 32'h09);

    d_clr = 1'b1;
    tick(1);
    check("clear_count", 32'(d_count), 32'h00);
    d_clr = 1'b0;
    tick(1);

    d_dec = 1'b1;
    tick(1);
    check("dec_wrap_count", 32'(d_count), 32'h99);
    check("dec_wrap_pulse", 32'(d_wrap), 32'h1);
    d_dec = 1'b0;
    tick(1);
    check("dec_wrap_end", 32'(d_wrap), 32'h0);
    check("dec_wrap_seg", 32'(d_seg), 32'h0810);
    d_inc = 1'b1;
    tick(1);
    check("inc_wrap_count", 32'(d_count), 32'h00);
    check("inc_wrap_pulse", 32'(d_wrap), 32'h1);
    d_inc = 1'b0;
    tick(1);
    check("inc_wrap_end", 32'(d_wrap), 32'h0);

    d_inc = 1'b1;
    tick(1);
    check("rep_k0", 32'(d_count), 32'h01);
    for (int i = 1; i < 10; i++) begin
      tick(1);
      check($sformatf("rep_k%0d", i), 32'(d_count), 32'(rep_exp[i]));
    end
    d_inc = 1'b0;
    tick(1);
    check("rep_release", 32'(d_count), 32'h04);
    tick(4);
    check("rep_after_release", 32'(d_count), 32'h04);

    d_dec = 1'b1;
    tick(1);
    check("both_dec_step", 32'(d_count), 32'h03);
    d_inc = 1'b1;
    tick(5);
    check("both_high_no_step", 32'(d_count), 32'h03);
    d_inc = 1'b0;
    tick(7);
    check("dec_still_held_no_step", 32'(d_count), 32'h03);
    d_dec = 1'b0;
    tick(1);
    d_dec = 1'b1;
    tick(1);
    check("dec_repress_step", 32'(d_count), 32'h02);
    d_dec = 1'b0;
    tick(1);

    for (int i = 0; i < 40; i++) pulse(0);
    check("reach_42", 32'(d_count), 32'h42);
    d_clr = 1'b1;
    d_inc = 1'b1;
    tick(1);
    check("clear_vs_inc_count", 32'(d_count), 32'h00);
    check("clear_vs_inc_wrap", 32'(d_wrap), 32'h0);
    d_clr = 1'b0;
    tick(6);
    check("after_clear_no_step", 32'(d_count), 32'h00);
    d_inc = 1'b0;
    tick(1);

    d_inc = 1'b1;
    tick(4);
    check("pre_abort_count", 32'(d_count), 32'h01);
    rst = 1'b1;
    tick(1);
    check("abort_rst_count", 32'(d_count), 32'h00);
    rst = 1'b0;
    tick(6);
    check("abort_no_step", 32'(d_count), 32'h00);
    d_inc = 1'b0;
    tick(1);

    h_inc = 1'b1;
    tick(7);
    check("hex_no_repeat", 32'(h_count), 32'h01);
    h_inc = 1'b0;
    tick(1);
    check("hex_seg_1", 32'(h_seg[6:0]), 32'(seg_tbl[1]));
    for (int v = 2; v <= 16; v++) begin
      pulse(2);
      check($sformatf("hex_count_%0d", v), 32'(h_count), 32'(v));
      check($sformatf("hex_seg_%0d", v), 32'(h_seg[6:0]), 32'(seg_tbl[v % 16]));
    end
    check("hex_carry_seg", 32'(h_seg), 32'h3CC0);
    pulse(3);
    check("hex_borrow_count", 32'(h_count), 32'h0F);
    h_clr = 1'b1;
    tick(1);
    h_clr = 1'b0;
    h_dec = 1'b1;
    tick(1);
    check("hex_wrap_count", 32'(h_count), 32'hFF);
    check("hex_wrap_pulse", 32'(h_wrap), 32'h1);
    h_dec = 1'b0;
    tick(1);
    check("hex_wrap_end", 32'(h_wrap), 32'h0);
    check("hex_ff_seg", 32'(h_seg), 32'h070E);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
